// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the instruction-fetch
// requester (i_*) and the load/store requester (d_*). One transaction is in
// flight at a time: IDLE arbitrates, ISSUE strobes the memory, WAIT counts the
// read latency, RESP returns a one-cycle response to the winner.
//
// Parameters
//   RD_LAT     : cycles from mem_en to valid mem_rdata (1..15)
//   STARVE_MAX : data wins tolerated by a waiting fetch before fetch is
//                forced to win (1..15); only used with ARB_STARVE_GUARD_EN
//
// Build option
//   ARB_STARVE_GUARD_EN : when defined, a saturating starvation counter
//                         forces a fetch win after STARVE_MAX consecutive
//                         data wins. When undefined, data always has priority.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr                  fetch request and word address
//   i_gnt/i_resp/i_rdata          fetch accept pulse, response pulse, data
//   d_req/d_we/d_addr/d_wdata     load/store request
//   d_gnt/d_resp/d_rdata          data accept pulse, response pulse, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           shared memory port
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_resp,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_resp,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Reject out-of-range configurations at elaboration.
    if (RD_LAT < 1 || RD_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_cfg_check
        $error("mem_port_arbiter: RD_LAT and STARVE_MAX must be in 1..15");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner_d;     // 1 = data owns the current transaction
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_lat;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        w_force_i;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_lat_done;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_starve;

    assign w_force_i = i_req && (r_starve == 4'(STARVE_MAX));

    // Counts consecutive data wins that left a fetch waiting; saturates so a
    // forced win stays armed until fetch actually gets through.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_grant_d && i_req) begin
                if (r_starve != 4'(STARVE_MAX)) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else if (w_grant_i) begin
                r_starve <= 4'd0;
            end
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    // Arbitration result; only acted upon while in IDLE.
    assign w_grant_d  = d_req && !w_force_i;
    assign w_grant_i  = i_req && !w_grant_d;
    assign w_lat_done = (r_lat == 4'(RD_LAT));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_req || d_req) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  if (w_lat_done) w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_d <= 1'b0;
            r_addr    <= 32'd0;
            r_we      <= 1'b0;
            r_wdata   <= 32'd0;
            r_lat     <= 4'd0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        r_addr    <= d_addr;
                        r_we      <= d_we;
                        r_wdata   <= d_wdata;
                    end else if (w_grant_i) begin
                        r_owner_d <= 1'b0;
                        r_addr    <= i_addr;
                        r_we      <= 1'b0;
                        r_wdata   <= 32'd0;
                    end
                end
                // The ISSUE cycle is latency cycle 1, so WAIT starts at 1.
                ST_ISSUE: r_lat <= 4'd1;
                ST_WAIT: begin
                    if (w_lat_done) begin
                        r_lat <= 4'd0;
                        if (r_owner_d) begin
                            r_d_rdata <= r_we ? 32'd0 : mem_rdata;
                        end else begin
                            r_i_rdata <= mem_rdata;
                        end
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = (r_state == ST_ISSUE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_gnt     = (r_state == ST_ISSUE) && !r_owner_d;
    assign d_gnt     = (r_state == ST_ISSUE) &&  r_owner_d;
    assign i_resp    = (r_state == ST_RESP)  && !r_owner_d;
    assign d_resp    = (r_state == ST_RESP)  &&  r_owner_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch path and the load/store path of the RV32I core. It is the step from separate `inst_mem`/`DataMem` arrays to a unified memory. It arbitrates between the two requesters, sequences exactly one memory transaction at a time with a fixed memory latency, and returns a one-cycle response pulse to the winning requester. It sits between the `PC`/`inst_mem` fetch side, the `DataMem` access side and the shared memory macro.

## Interface
- `RD_LAT`, 1, memory cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.
- `STARVE_MAX`, 4, consecutive lost arbitrations tolerated by fetch before it is forced to win; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high with stable `i_addr` until `i_resp`.
- `i_addr`  in  32  fetch word address.
- `i_gnt`  out  1  one-cycle pulse: fetch request accepted.
- `i_resp`  out  1  one-cycle pulse: `i_rdata` valid.
- `i_rdata`  out  32  fetched instruction.
- `d_req`  in  1  data request; held high with stable `d_we`/`d_addr`/`d_wdata` until `d_resp`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  one-cycle pulse: data request accepted.
- `d_resp`  out  1  one-cycle pulse: load data valid, or store complete.
- `d_rdata`  out  32  load data; 0 on a store response.
- `mem_en`  out  1  one-cycle memory strobe.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data, valid exactly `RD_LAT` cycles after `mem_en`.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: `mem_en` high for one cycle.
  - WAIT: count `RD_LAT`.
  - RESP: response pulse.
- Transitions:
  - IDLE→ISSUE when `i_req|d_req`.
  - ISSUE→WAIT.
  - WAIT→RESP when the latency counter reaches `RD_LAT`.
  - RESP→IDLE.
- Arbitration happens only in IDLE.
  - Fixed priority: data over fetch.
  - Exception: fetch wins if `i_req` is high and the starvation counter equals `STARVE_MAX`.
- At IDLE→ISSUE the block registers the owner (I or D), address, we and wdata.
  - `mem_addr`/`mem_we`/`mem_wdata` hold the latched values from ISSUE through RESP.
  - `mem_we` is 0 for fetch.
- The owner's `x_gnt` pulses in the ISSUE cycle.
- RESP cycle:
  - The owner's `x_resp` is high.
  - `x_rdata` holds `mem_rdata` captured at the WAIT→RESP edge (0 for a store).
  - `x_rdata` holds its value until the next response to that port.
- Requests are not accepted in RESP. A requester drops `req` after seeing `resp`, or keeps it high to request again.
- Starvation counter (4 bits, saturating at `STARVE_MAX`):
  - increments when data wins in IDLE while `i_req` is high;
  - clears when fetch wins.
- At most one transaction is outstanding. The non-owner's `req` is ignored until the next IDLE.

## Timing
- Reset: state IDLE. All outputs are 0, including `i_rdata`, `d_rdata` and `mem_*`. The starvation counter and latency counter are 0.
- Request visible in cycle 0 (IDLE) → `gnt` and `mem_en` in cycle 1 → `mem_rdata` valid in cycle 1+`RD_LAT` → `resp` in cycle 2+`RD_LAT` → IDLE in cycle 3+`RD_LAT`.
- Throughput: one transaction per 3+`RD_LAT` cycles with back-to-back requests.
- Simultaneous `i_req` and `d_req` in IDLE: data wins unless starvation forces fetch. The loser's request stays pending and competes in the next IDLE.
- `rst` asserted in any state:
  - the next state is IDLE;
  - the in-flight transaction is dropped: no `resp`, and no further `mem_en`;
  - a `mem_en` already issued is not retracted.
- A requester changing address while its request is pending is illegal. The arbiter uses the value latched at grant.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: the starvation counter and forced fetch win are compiled in, as described above.
- `ARB_STARVE_GUARD_EN` undefined: pure fixed priority with data always first. There is no counter, and fetch can starve indefinitely under continuous `d_req`. `STARVE_MAX` is unused.

## Test plan
- Reset and fetch timing: assert `rst` for 2 cycles and check every output is 0. With `RD_LAT`=2, hold `i_req` at address 0x0 in cycle 0 → `i_gnt`/`mem_en` in cycle 1 → `i_resp` in cycle 4 with `i_rdata` = mem[0x0] = 0x00500093.
- Collision: `i_req` and `d_req` (load from 0x100) both high in the same cycle → `d_gnt` first, `d_resp` with mem[0x100]. `i_gnt` is in the next IDLE, 3+`RD_LAT` cycles after `d_gnt`.
- Store then load: `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF → `mem_we`=1 on the `mem_en` cycle, `d_resp` with `d_rdata`=0. A following load of 0x40 returns 0xDEADBEEF.
- Starvation with the macro defined: `d_req` held high continuously, `i_req` high, `STARVE_MAX`=4 → exactly 4 `d_gnt`s, then `i_gnt`, then data resumes. With the macro undefined: no `i_gnt` in 50 transactions.
- Reset mid-operation: with `RD_LAT`=3, assert `rst` during WAIT → no `d_resp` ever for that transaction. The next `i_req` is granted normally one cycle after `rst` deasserts.
